// File: rtl/alien_march_ctrl_pkg.sv
// alien_march_ctrl_pkg: march states, game-state code and screen/formation geometry
// shared by the alien march controller and the renderer.
package alien_march_ctrl_pkg;

    localparam int SCREEN_W    = 640;
    localparam int BOTTOM_Y    = 400;
    localparam int FORM_H      = 128;
    localparam int START_X     = 160;
    localparam int START_Y     = 48;
    localparam int STEP_X      = 8;
    localparam int STEP_Y      = 16;
    localparam int BASE_PERIOD = 30;
    localparam int MIN_PERIOD  = 2;

    localparam logic [1:0] GS_PLAY_GAME = 2'd2;

    typedef enum logic [1:0] {WAIT, MOVE, DESCEND, HALT} march_state_t;

    // Frames per step for a round; round 0 counts as round 1, floor at MIN_PERIOD.
    function automatic logic [6:0] round_period(input logic [4:0] round);
        logic [6:0] r1;
        logic [7:0] dec;
        r1  = (round == 5'd0) ? 7'd0 : 7'(round) - 7'd1;
        dec = {r1, 1'b0};
        return (dec + 8'(MIN_PERIOD) >= 8'(BASE_PERIOD)) ? 7'(MIN_PERIOD) : 7'(8'(BASE_PERIOD) - dec);
    endfunction

endpackage

// File: rtl/alien_march_ctrl_march_period_calc.sv
// march_period_calc: registered frames-per-step from round, 1-cycle latency.
// SPEEDUP_ON_KILLS_EN adds aliens_remaining and the late-wave speedup.
module march_period_calc
    import alien_march_ctrl_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [4:0] round,
`ifdef SPEEDUP_ON_KILLS_EN
    input  logic [5:0] aliens_remaining,
`endif
    output logic [6:0] period
);

    logic [6:0] base;
    logic [6:0] eff;

    always_comb begin
        base = round_period(round);
`ifdef SPEEDUP_ON_KILLS_EN
        eff = (aliens_remaining == 6'd1) ? 7'(MIN_PERIOD) :
              (aliens_remaining <= 6'd8) ? (((base >> 1) < 7'(MIN_PERIOD)) ? 7'(MIN_PERIOD) : (base >> 1)) :
              base;
`else
        eff = base;
`endif
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) period <= 7'(BASE_PERIOD);
        else     period <= eff;
    end

endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: frame-paced march/descend/reverse sequencer for the alien formation.
// SPEEDUP_ON_KILLS_EN adds aliens_remaining to shorten the step period late in a wave.
module alien_march_ctrl
    import alien_march_ctrl_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic       alien_rst,
    input  logic [1:0] game_state,
    input  logic [4:0] round,
`ifdef SPEEDUP_ON_KILLS_EN
    input  logic [5:0] aliens_remaining,
`endif
    input  logic [9:0] live_left_off,
    input  logic [9:0] live_right_off,
    output logic [9:0] formation_x,
    output logic [9:0] formation_y,
    output logic       march_dir,
    output logic       step_pulse,
    output logic       reached_bottom
);

    march_state_t state;
    logic [6:0] period;
    logic [6:0] frame_cnt;
    logic [9:0] next_y;
    logic       edge_hit;
    logic       at_bottom;
    logic       due;

    march_period_calc u_period (
        .pixel_clk        (pixel_clk),
        .rst              (rst),
        .round            (round),
`ifdef SPEEDUP_ON_KILLS_EN
        .aliens_remaining (aliens_remaining),
`endif
        .period           (period)
    );

    // Greater-or-equal rather than equality so a mid-count period drop steps on the next frame.
    always_comb begin
        due       = ({1'b0, frame_cnt} + 8'd1) >= {1'b0, period};
        edge_hit  = march_dir ? (11'(formation_x) + 11'(live_right_off) + 11'(STEP_X) > 11'(SCREEN_W))
                              : (11'(formation_x) + 11'(live_left_off) < 11'(STEP_X));
        next_y    = formation_y + 10'(STEP_Y);
        at_bottom = 11'(next_y) + 11'(FORM_H) >= 11'(BOTTOM_Y);
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            formation_x    <= 10'(START_X);
            formation_y    <= 10'(START_Y);
            march_dir      <= 1'b1;
            step_pulse     <= 1'b0;
            reached_bottom <= 1'b0;
            frame_cnt      <= 7'd0;
            state          <= WAIT;
        end else if (alien_rst) begin
            formation_x    <= 10'(START_X);
            formation_y    <= 10'(START_Y);
            march_dir      <= 1'b1;
            step_pulse     <= 1'b0;
            reached_bottom <= 1'b0;
            frame_cnt      <= 7'd0;
            state          <= WAIT;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                WAIT: if (fsync && game_state == GS_PLAY_GAME) begin
                    if (due) begin
                        frame_cnt <= 7'd0;
                        state     <= edge_hit ? DESCEND : MOVE;
                    end else begin
                        frame_cnt <= frame_cnt + 7'd1;
                    end
                end
                MOVE: begin
                    formation_x <= march_dir ? formation_x + 10'(STEP_X) : formation_x - 10'(STEP_X);
                    step_pulse  <= 1'b1;
                    state       <= WAIT;
                end
                DESCEND: begin
                    formation_y    <= next_y;
                    march_dir      <= ~march_dir;
                    step_pulse     <= 1'b1;
                    reached_bottom <= at_bottom;
                    state          <= at_bottom ? HALT : WAIT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// tb_alien_march_ctrl: randomized scenarios checked against a frame-level march model.
module tb_alien_march_ctrl;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       fsync = 1'b0;
    logic       alien_rst = 1'b0;
    logic [1:0] game_state = 2'd2;
    logic [4:0] round = 5'd1;
    logic [9:0] lo = 10'd0;
    logic [9:0] ro = 10'd320;
    logic [9:0] formation_x, formation_y;
    logic       march_dir, step_pulse, reached_bottom;
`ifdef SPEEDUP_ON_KILLS_EN
    logic [5:0] aliens_remaining = 6'd40;
`endif

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int mx, my, mdir, mbot, mcnt, msteps;

    alien_march_ctrl dut (
        .pixel_clk        (pixel_clk),
        .rst              (rst),
        .fsync            (fsync),
        .alien_rst        (alien_rst),
        .game_state       (game_state),
        .round            (round),
`ifdef SPEEDUP_ON_KILLS_EN
        .aliens_remaining (aliens_remaining),
`endif
        .live_left_off    (lo),
        .live_right_off   (ro),
        .formation_x      (formation_x),
        .formation_y      (formation_y),
        .march_dir        (march_dir),
        .step_pulse       (step_pulse),
        .reached_bottom   (reached_bottom)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk) if (step_pulse === 1'b1) pulses++;

    function automatic int ref_period();
        int r, p;
        r = (round == 0) ? 1 : int'(round);
        p = 30 - 2 * (r - 1);
        if (p < 2) p = 2;
`ifdef SPEEDUP_ON_KILLS_EN
        if (aliens_remaining == 1) p = 2;
        else if (aliens_remaining <= 8) p = (p / 2 < 2) ? 2 : p / 2;
`endif
        return p;
    endfunction

    task automatic model_reset();
        mx = 160; my = 48; mdir = 1; mbot = 0; mcnt = 0;
    endtask

    task automatic do_alien_rst();
        @(negedge pixel_clk) alien_rst = 1'b1;
        @(negedge pixel_clk) alien_rst = 1'b0;
        model_reset();
    endtask

    task automatic set_round(input int r);
        @(negedge pixel_clk) round = 5'(r);
        repeat (2) @(negedge pixel_clk);
    endtask

    // One frame: every counted frame advances the count; the P-th counted frame takes a step.
    task automatic tick_fsync();
        @(negedge pixel_clk) fsync = 1'b1;
        if (game_state == 2'd2 && mbot == 0) begin
            if (mcnt + 1 >= ref_period()) begin
                mcnt = 0;
                msteps++;
                if (mdir != 0 ? (mx + int'(ro) + 8 > 640) : (mx + int'(lo) < 8)) begin
                    my += 16;
                    mdir = 1 - mdir;
                    if (my + 128 >= 400) mbot = 1;
                end else begin
                    mx += (mdir != 0) ? 8 : -8;
                end
            end else begin
                mcnt++;
            end
        end
        @(negedge pixel_clk) fsync = 1'b0;
        repeat (3) @(negedge pixel_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pixel_clk);
        total++;
        if (formation_x !== 10'd160 || formation_y !== 10'd48 || march_dir !== 1'b1 ||
            step_pulse !== 1'b0 || reached_bottom !== 1'b0) begin
            bad++;
            $display("FAIL reset: got x=%0d y=%0d dir=%0d pulse=%0d bot=%0d want 160/48/1/0/0",
                     formation_x, formation_y, march_dir, step_pulse, reached_bottom);
        end
        rst = 1'b0;
        model_reset();
        msteps = 0;
        repeat (4) @(negedge pixel_clk);
        total++;
        if (pulses !== 0 || formation_x !== 10'd160) begin
            bad++;
            $display("FAIL reset_release: got pulses=%0d x=%0d want 0/160", pulses, formation_x);
        end
    endtask

    task automatic test_round1();
        int p0;
        do_alien_rst();
        set_round(1);
        lo = 10'd0; ro = 10'd320; game_state = 2'd2;
        p0 = pulses;
        repeat (29) tick_fsync();
        total++;
        if (formation_x !== 10'd160 || pulses !== p0) begin
            bad++;
            $display("FAIL round1_early: got x=%0d pulses=%0d want x=160 pulses=%0d", formation_x, pulses - p0, 0);
        end
        tick_fsync();
        total++;
        if (formation_x !== 10'd168 || formation_y !== 10'd48 || pulses !== p0 + 1) begin
            bad++;
            $display("FAIL round1_step: got x=%0d y=%0d pulses=%0d want x=168 y=48 pulses=1",
                     formation_x, formation_y, pulses - p0);
        end
    endtask

    task automatic test_periods();
        int rounds[6];
        rounds = '{11, 31, 0, $urandom_range(2, 16), $urandom_range(1, 31), $urandom_range(5, 20)};
        for (int k = 0; k < 6; k++) begin
            do_alien_rst();
            set_round(rounds[k]);
            lo = 10'($urandom_range(0, 7));
            ro = 10'($urandom_range(64, 300));
            for (int n = 0; n < int'($urandom_range(25, 45)); n++) begin
                game_state = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
                tick_fsync();
                total++;
                if (formation_x !== 10'(mx) || formation_y !== 10'(my) || march_dir !== 1'(mdir) ||
                    pulses !== msteps) begin
                    bad++;
                    $display("FAIL period r=%0d: got x=%0d y=%0d dir=%0d pulses=%0d want %0d/%0d/%0d/%0d",
                             rounds[k], formation_x, formation_y, march_dir, pulses, mx, my, mdir, msteps);
                end
            end
        end
        game_state = 2'd2;
    endtask

    task automatic test_descend_at_edge();
        do_alien_rst();
        set_round(31);
        lo = 10'd0; ro = 10'd328;
        repeat (40) tick_fsync();
        total++;
        if (formation_x !== 10'd312 || formation_y !== 10'd64 || march_dir !== 1'b0 || pulses !== msteps) begin
            bad++;
            $display("FAIL edge_descend: got x=%0d y=%0d dir=%0d want 312/64/0", formation_x, formation_y, march_dir);
        end
    endtask

    task automatic test_bottom();
        int n;
        int hold_x, hold_p;
        do_alien_rst();
        set_round(31);
        lo = 10'($urandom_range(0, 7));
        ro = 10'($urandom_range(300, 480));
        n = 0;
        while (mbot == 0 && n < 3000) begin
            tick_fsync();
            n++;
            total++;
            if (formation_x !== 10'(mx) || formation_y !== 10'(my) || march_dir !== 1'(mdir) ||
                reached_bottom !== 1'(mbot) || pulses !== msteps) begin
                bad++;
                $display("FAIL march n=%0d: got x=%0d y=%0d dir=%0d bot=%0d pulses=%0d want %0d/%0d/%0d/%0d/%0d",
                         n, formation_x, formation_y, march_dir, reached_bottom, pulses, mx, my, mdir, mbot, msteps);
            end
        end
        total++;
        if (reached_bottom !== 1'b1 || formation_y !== 10'd272) begin
            bad++;
            $display("FAIL bottom: got bot=%0d y=%0d want 1/272", reached_bottom, formation_y);
        end
        hold_x = int'(formation_x);
        hold_p = pulses;
        repeat (6) tick_fsync();
        total++;
        if (int'(formation_x) !== hold_x || formation_y !== 10'd272 || reached_bottom !== 1'b1 || pulses !== hold_p) begin
            bad++;
            $display("FAIL halt: got x=%0d y=%0d bot=%0d pulses=%0d want %0d/272/1/%0d",
                     formation_x, formation_y, reached_bottom, pulses, hold_x, hold_p);
        end
        do_alien_rst();
        repeat (2) @(negedge pixel_clk);
        total++;
        if (reached_bottom !== 1'b0 || formation_y !== 10'd48 || formation_x !== 10'd160 || march_dir !== 1'b1) begin
            bad++;
            $display("FAIL halt_exit: got bot=%0d x=%0d y=%0d dir=%0d want 0/160/48/1",
                     reached_bottom, formation_x, formation_y, march_dir);
        end
    endtask

    task automatic test_alien_rst_collision();
        int p0;
        do_alien_rst();
        set_round(31);
        lo = 10'd0; ro = 10'd200;
        repeat (3) tick_fsync();
        p0 = pulses;
        @(negedge pixel_clk) begin fsync = 1'b1; alien_rst = 1'b1; end
        @(negedge pixel_clk) begin fsync = 1'b0; alien_rst = 1'b0; end
        model_reset();
        repeat (4) @(negedge pixel_clk);
        total++;
        if (formation_x !== 10'd160 || formation_y !== 10'd48 || march_dir !== 1'b1 || pulses !== p0) begin
            bad++;
            $display("FAIL rst_collision: got x=%0d y=%0d dir=%0d pulses=%0d want 160/48/1/%0d",
                     formation_x, formation_y, march_dir, pulses, p0);
        end
        msteps = pulses;
        tick_fsync();
        total++;
        if (pulses !== msteps || formation_x !== 10'(mx)) begin
            bad++;
            $display("FAIL rst_count_cleared: got pulses=%0d x=%0d want %0d/%0d", pulses, formation_x, msteps, mx);
        end
    endtask

    task automatic test_not_play();
        int p0;
        do_alien_rst();
        set_round(1);
        lo = 10'd0; ro = 10'd320;
        repeat (10) tick_fsync();
        p0 = pulses;
        for (int n = 0; n < 50; n++) begin
            game_state = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 1) * 2 + 1);
            tick_fsync();
        end
        total++;
        if (pulses !== p0 || formation_x !== 10'd160) begin
            bad++;
            $display("FAIL not_play: got pulses=%0d x=%0d want %0d/160", pulses, formation_x, p0);
        end
        game_state = 2'd2;
        repeat (19) tick_fsync();
        total++;
        if (pulses !== p0 || formation_x !== 10'(mx)) begin
            bad++;
            $display("FAIL count_held_early: got pulses=%0d x=%0d want %0d/%0d", pulses, formation_x, p0, mx);
        end
        tick_fsync();
        total++;
        if (pulses !== p0 + 1 || formation_x !== 10'd168 || pulses !== msteps) begin
            bad++;
            $display("FAIL count_held_step: got pulses=%0d x=%0d want %0d/168", pulses, formation_x, p0 + 1);
        end
    endtask

    task automatic test_round_drop();
        do_alien_rst();
        set_round(1);
        lo = 10'd0; ro = 10'd320;
        repeat (20) tick_fsync();
        set_round(11);
        tick_fsync();
        total++;
        if (formation_x !== 10'd168 || pulses !== msteps) begin
            bad++;
            $display("FAIL round_drop: got x=%0d pulses=%0d want 168/%0d", formation_x, pulses, msteps);
        end
        repeat (10) tick_fsync();
        total++;
        if (formation_x !== 10'(mx) || pulses !== msteps) begin
            bad++;
            $display("FAIL round_drop_next: got x=%0d pulses=%0d want %0d/%0d", formation_x, pulses, mx, msteps);
        end
    endtask

`ifdef SPEEDUP_ON_KILLS_EN
    task automatic test_speedup();
        int left[4];
        left = '{8, 1, 9, int'($urandom_range(0, 12))};
        for (int k = 0; k < 4; k++) begin
            do_alien_rst();
            @(negedge pixel_clk) aliens_remaining = 6'(left[k]);
            set_round(1);
            lo = 10'd0; ro = 10'd320;
            for (int n = 0; n < 32; n++) begin
                tick_fsync();
                total++;
                if (formation_x !== 10'(mx) || pulses !== msteps) begin
                    bad++;
                    $display("FAIL speedup ar=%0d n=%0d: got x=%0d pulses=%0d want %0d/%0d",
                             left[k], n, formation_x, pulses, mx, msteps);
                end
            end
        end
        aliens_remaining = 6'd40;
    endtask
`endif

    initial begin
        test_reset();
        test_round1();
        test_periods();
        test_descend_at_edge();
        test_bottom();
        test_alien_rst_collision();
        test_not_play();
        test_round_drop();
`ifdef SPEEDUP_ON_KILLS_EN
        test_speedup();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
